// File: rtl/img_pkg.sv
// -----------------------------------------------------------------------------
// img_pkg
// Shared definitions for the image frame reader and its pixel operator:
//   - point-operation mode encoding (mode_e)
//   - frame sequencer state encoding (state_e)
//   - pixel channel width and bits per pixel
//   - gray3(): floor((R+G+B)/3) of one RGB888 pixel
// -----------------------------------------------------------------------------
package img_pkg;

   localparam int PIX_W = 8;    // bits per colour channel
   localparam int BPP   = 24;   // bits per pixel, {R,G,B}

   typedef enum logic [1:0] {
      MODE_BYPASS = 2'b00,
      MODE_BRIGHT = 2'b01,
      MODE_INVERT = 2'b10,
      MODE_THRESH = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_VSYNC = 3'd1,
      ST_HGAP  = 3'd2,
      ST_DATA  = 3'd3,
      ST_DRAIN = 3'd4
   } state_e;

   // Gray level of a {R,G,B} pixel. The 10-bit sum cannot overflow (max 765)
   // and the quotient always fits back into one channel.
   function automatic logic [PIX_W-1:0] gray3(input logic [BPP-1:0] pix);
      logic [9:0] sum;
      sum = 10'(pix[23:16]) + 10'(pix[15:8]) + 10'(pix[7:0]);
      return PIX_W'(sum / 10'd3);
   endfunction

endpackage

// File: rtl/img_pix_op.sv
// -----------------------------------------------------------------------------
// img_pix_op
// Combinational point operation on one RGB888 pixel.
// Ports:
//   mode_i      operation select (bypass / brightness / invert-gray / threshold)
//   value_i     brightness offset
//   sign_i      1 = add offset, 0 = subtract offset
//   threshold_i threshold level compared against the gray value
//   pix_i       input pixel {R,G,B}
//   pix_o       result pixel {R,G,B}
// -----------------------------------------------------------------------------
module img_pix_op
   import img_pkg::*;
(
   input  mode_e            mode_i,
   input  logic [PIX_W-1:0] value_i,
   input  logic             sign_i,
   input  logic [PIX_W-1:0] threshold_i,
   input  logic [BPP-1:0]   pix_i,
   output logic [BPP-1:0]   pix_o
);

   logic [PIX_W-1:0] gray;
   logic [BPP-1:0]   bright;

   assign gray = gray3(pix_i);

   // Brightness: 9-bit sum/difference per channel; the carry/borrow bit
   // selects the saturation value.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_ch
         logic [PIX_W-1:0] ch;
         logic [PIX_W:0]   sum;
         logic [PIX_W:0]   diff;

         assign ch   = pix_i[gi*PIX_W +: PIX_W];
         assign sum  = {1'b0, ch} + {1'b0, value_i};
         assign diff = {1'b0, ch} - {1'b0, value_i};
         assign bright[gi*PIX_W +: PIX_W] =
            sign_i ? (sum[PIX_W]  ? {PIX_W{1'b1}} : sum[PIX_W-1:0])
                   : (diff[PIX_W] ? {PIX_W{1'b0}} : diff[PIX_W-1:0]);
      end
   endgenerate

   always_comb begin
      pix_o = pix_i;
      case (mode_i)
         MODE_BYPASS: pix_o = pix_i;
         MODE_BRIGHT: pix_o = bright;
         MODE_INVERT: pix_o = {3{~gray}};   // 255 - gray
         MODE_THRESH: pix_o = (gray > threshold_i) ? {BPP{1'b1}} : {BPP{1'b0}};
         default:     pix_o = pix_i;
      endcase
   end

endmodule

// File: rtl/image_frame_reader.sv
// -----------------------------------------------------------------------------
// image_frame_reader
// Reads an RGB888 frame (PPC pixels per memory word) from a synchronous frame
// memory, applies a per-frame point operation and emits a valid/ready pixel
// stream framed with VSYNC/HSYNC and end-of-line / end-of-frame markers.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   start                frame start pulse (dropped while busy)
//   mode/value/sign/threshold
//                        point-operation controls, latched on accepted start
//   mem_rd_en, mem_addr  memory read strobe and word address
//   mem_rd_data          read data, valid the cycle after mem_rd_en
//   out_valid/out_ready  output handshake
//   out_data             PPC pixels, pixel k at [24k+23:24k] = {R,G,B}
//   out_eol, out_eof     last beat of line / frame (qualified by out_valid)
//   VSYNC                high during the start-up delay
//   HSYNC                mirrors out_valid
//   busy                 sequencer active or output FIFO non-empty
//   ctrl_done            one-cycle pulse after the end-of-frame handshake
//   frame_cnt            completed frames, wraps
//
// Build option:
//   IMG_CONTINUOUS_EN    when defined, a finished frame restarts at VSYNC
//                        without a start pulse, re-latching the controls.
// -----------------------------------------------------------------------------
module image_frame_reader
   import img_pkg::*;
#(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int PPC            = 2,
   parameter int START_UP_DELAY = 100,
   parameter int HSYNC_DELAY    = 160,
   parameter int BOTTOM_UP      = 1,
   parameter int AW             = $clog2(WIDTH*HEIGHT/PPC)
)(
   input  logic                 HCLK,
   input  logic                 HRESETn,
   input  logic                 start,
   input  logic [1:0]           mode,
   input  logic [7:0]           value,
   input  logic                 sign,
   input  logic [7:0]           threshold,
   output logic                 mem_rd_en,
   output logic [AW-1:0]        mem_addr,
   input  logic [BPP*PPC-1:0]   mem_rd_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BPP*PPC-1:0]   out_data,
   output logic                 out_eol,
   output logic                 out_eof,
   output logic                 VSYNC,
   output logic                 HSYNC,
   output logic                 busy,
   output logic                 ctrl_done,
   output logic [15:0]          frame_cnt
);

   localparam int WPL    = WIDTH / PPC;                          // words per line
   localparam int DATA_W = BPP * PPC;
   localparam int RW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DMAX   = (START_UP_DELAY > HSYNC_DELAY) ? START_UP_DELAY : HSYNC_DELAY;
   localparam int DLY_W  = $clog2(DMAX + 1);

   // ---------------------------------------------------------------- state
   state_e             state_q;
   logic [DLY_W-1:0]   dly_q;
   logic [RW-1:0]      row_q;
   logic [CW-1:0]      col_q;
   mode_e              mode_q;
   logic [PIX_W-1:0]   value_q;
   logic               sign_q;
   logic [PIX_W-1:0]   thr_q;
   logic               rd_pend_q;     // read issued last cycle, data arrives now
   logic               pend_eol_q;
   logic               pend_eof_q;

   // FIFO entry = {eof, eol, data}
   logic [DATA_W+1:0]  fifo_q [2];
   logic               wr_ptr_q;
   logic               rd_ptr_q;
   logic [1:0]         count_q;
   logic [1:0]         count_d;
   logic               ctrl_done_q;
   logic [15:0]        frame_cnt_q;

   // ---------------------------------------------------------- read issue
   logic [1:0]         occ;
   logic               issue;
   logic               last_col;
   logic               last_row;
   logic [RW-1:0]      rowm;

   // Occupancy plus the read whose data lands this cycle; a new read is only
   // issued while this stays below the FIFO depth, so the FIFO never overflows.
   assign occ      = count_q + {1'b0, rd_pend_q};
   assign issue    = (state_q == ST_DATA) && (occ < 2'd2);
   assign last_col = (col_q == CW'(WIDTH - PPC));
   assign last_row = (row_q == RW'(HEIGHT - 1));
   assign rowm     = (BOTTOM_UP != 0) ? (RW'(HEIGHT - 1) - row_q) : row_q;

   // The strobe is decoded from registered state and FIFO credit so that the
   // credit check always sees the current occupancy.
   assign mem_rd_en = issue;
   assign mem_addr  = issue ? AW'(32'(rowm) * 32'(WPL) + 32'(col_q) / 32'(PPC))
                            : {AW{1'b0}};

   // ------------------------------------------------------------ sequencer
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         dly_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         mode_q     <= MODE_BYPASS;
         value_q    <= '0;
         sign_q     <= 1'b0;
         thr_q      <= '0;
         rd_pend_q  <= 1'b0;
         pend_eol_q <= 1'b0;
         pend_eof_q <= 1'b0;
      end else begin
         // Line/frame markers travel with the read so they land in the FIFO
         // together with the returned word.
         rd_pend_q  <= issue;
         pend_eol_q <= issue && last_col;
         pend_eof_q <= issue && last_col && last_row;

         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  mode_q  <= mode_e'(mode);
                  value_q <= value;
                  sign_q  <= sign;
                  thr_q   <= threshold;
                  dly_q   <= '0;
                  state_q <= ST_VSYNC;
               end
            end

            ST_VSYNC: begin
               if (dly_q == DLY_W'(START_UP_DELAY - 1)) begin
                  dly_q   <= '0;
                  state_q <= ST_HGAP;
               end else begin
                  dly_q <= dly_q + DLY_W'(1);
               end
            end

            ST_HGAP: begin
               if (dly_q == DLY_W'(HSYNC_DELAY - 1)) begin
                  dly_q   <= '0;
                  state_q <= ST_DATA;
               end else begin
                  dly_q <= dly_q + DLY_W'(1);
               end
            end

            ST_DATA: begin
               if (issue) begin
                  if (last_col) begin
                     col_q <= '0;
                     if (last_row) begin
                        row_q   <= '0;
                        state_q <= ST_DRAIN;
                     end else begin
                        row_q   <= row_q + RW'(1);
                        state_q <= ST_HGAP;
                     end
                  end else begin
                     col_q <= col_q + CW'(PPC);
                  end
               end
            end

            ST_DRAIN: begin
               if ((count_q == 2'd0) && !rd_pend_q) begin
`ifdef IMG_CONTINUOUS_EN
                  mode_q  <= mode_e'(mode);
                  value_q <= value;
                  sign_q  <= sign;
                  thr_q   <= threshold;
                  dly_q   <= '0;
                  state_q <= ST_VSYNC;
`else
                  state_q <= ST_IDLE;
`endif
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------ point operation
   logic [DATA_W-1:0] op_data;

   generate
      for (genvar gi = 0; gi < PPC; gi++) begin : g_pix
         img_pix_op u_pix_op (
            .mode_i      (mode_q),
            .value_i     (value_q),
            .sign_i      (sign_q),
            .threshold_i (thr_q),
            .pix_i       (mem_rd_data[gi*BPP +: BPP]),
            .pix_o       (op_data[gi*BPP +: BPP])
         );
      end
   endgenerate

   // ---------------------------------------------------------- output FIFO
   logic               push;
   logic               pop;
   logic [DATA_W+1:0]  head;

   assign push = rd_pend_q;
   assign head = fifo_q[rd_ptr_q];
   assign pop  = (count_q != 2'd0) && out_ready;

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < 2; i++) begin
            fifo_q[i] <= '0;
         end
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= 2'd0;
         ctrl_done_q <= 1'b0;
         frame_cnt_q <= 16'd0;
      end else begin
         // With a full FIFO the write slot equals the head being popped, so a
         // simultaneous push/pop replaces the departing entry.
         if (push) begin
            fifo_q[wr_ptr_q] <= {pend_eof_q, pend_eol_q, op_data};
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q     <= count_d;
         ctrl_done_q <= pop && head[DATA_W+1];
         if (ctrl_done_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   // --------------------------------------------------------------- outputs
   assign out_valid = (count_q != 2'd0);
   assign out_data  = head[DATA_W-1:0];
   assign out_eol   = head[DATA_W];
   assign out_eof   = head[DATA_W+1];
   assign HSYNC     = out_valid;
   assign VSYNC     = (state_q == ST_VSYNC);
   assign busy      = (state_q != ST_IDLE) || (count_q != 2'd0);
   assign ctrl_done = ctrl_done_q;
   assign frame_cnt = frame_cnt_q;

endmodule
